hit_ungap_extender: RTL and testbench

HIT_UNGAP_EXTENDER -- requirements
Module: hit_ungap_extender

---
 rtl/blastn_pkg.sv | 35 +++
 rtl/ungap_dir_scorer.sv | 97 +++++++++
 rtl/hit_ungap_extender.sv | 233 +++++++++++++++++++++++
 tb/tb_hit_ungap_extender.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/blastn_pkg.sv
// Shared BLASTN definitions: nucleotide codes, datapath widths, default scoring and the extender FSM states.
`default_nettype none

package blastn_pkg;

    localparam int LENGTH_CHAR    = 3;
    localparam int LENGTH_COUNTER = 8;
    localparam int SCORE_W        = 10;

    localparam int MATCH_DEF    = 1;
    localparam int MISMATCH_DEF = 3;
    localparam int X_DROP_DEF   = 10;

    localparam logic [LENGTH_CHAR-1:0] NT_BOUNDARY = 3'b000;
    localparam logic [LENGTH_CHAR-1:0] NT_A        = 3'b001;
    localparam logic [LENGTH_CHAR-1:0] NT_G        = 3'b010;
    localparam logic [LENGTH_CHAR-1:0] NT_T        = 3'b011;
    localparam logic [LENGTH_CHAR-1:0] NT_C        = 3'b100;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        POP    = 3'd1,
        LOAD   = 3'd2,
        EXTEND = 3'd3,
        REPORT = 3'd4
    } ext_state_t;

    // Clamp an internal sum to the external counter width.
    function automatic logic [LENGTH_COUNTER-1:0] sat_count(input logic [SCORE_W-1:0] v);
        return (v > SCORE_W'(2**LENGTH_COUNTER - 1)) ? '1 : v[LENGTH_COUNTER-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/ungap_dir_scorer.sv
// One extension direction: scores each returned pair, tracks best score/length and decides when to stop.
`default_nettype none

module ungap_dir_scorer
    import blastn_pkg::*;
#(
    parameter int LENGTH_CHAR    = blastn_pkg::LENGTH_CHAR,
    parameter int LENGTH_COUNTER = blastn_pkg::LENGTH_COUNTER,
    parameter int MATCH          = blastn_pkg::MATCH_DEF,
    parameter int MISMATCH       = blastn_pkg::MISMATCH_DEF,
    parameter int X_DROP         = blastn_pkg::X_DROP_DEF,
    parameter int MAX_EXT        = 32,
    parameter bit FORWARD        = 1'b1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             start_ok,
    input  logic [LENGTH_COUNTER-1:0]        start_q,
    input  logic [LENGTH_COUNTER-1:0]        start_s,
    input  logic                             score_en,
    input  logic [LENGTH_CHAR-1:0]           q_char,
    input  logic [LENGTH_CHAR-1:0]           s_char,
    output logic                             active,
    output logic signed [SCORE_W-1:0]        best,
    output logic [LENGTH_COUNTER-1:0]        best_len
);

    localparam logic signed [SCORE_W-1:0]  INC   = SCORE_W'(MATCH);
    localparam logic signed [SCORE_W-1:0]  DEC   = SCORE_W'(MISMATCH);
    localparam logic signed [SCORE_W-1:0]  DROP  = SCORE_W'(X_DROP);
    localparam logic [LENGTH_COUNTER-1:0]  LIMIT = LENGTH_COUNTER'(MAX_EXT);
    localparam logic [LENGTH_COUNTER-1:0]  EDGE  = FORWARD ? '1 : '0;

    logic signed [SCORE_W-1:0]   run_score;
    logic [LENGTH_COUNTER-1:0]   count;
    logic [LENGTH_COUNTER-1:0]   base_q;
    logic [LENGTH_COUNTER-1:0]   base_s;

    logic                        hit_boundary;
    logic signed [SCORE_W-1:0]   next_run;
    logic signed [SCORE_W-1:0]   next_best;
    logic [LENGTH_COUNTER-1:0]   next_count;
    logic [LENGTH_COUNTER-1:0]   q_addr;
    logic [LENGTH_COUNTER-1:0]   s_addr;
    logic                        at_edge;
    logic                        stop;

    // The pair being scored sits 'count' characters away from the direction's start address.
    always_comb begin
        hit_boundary = (q_char == NT_BOUNDARY) || (s_char == NT_BOUNDARY);
        next_run     = (q_char == s_char) ? run_score + INC : run_score - DEC;
        next_best    = (next_run > best) ? next_run : best;
        next_count   = count + 1'b1;
        q_addr       = FORWARD ? base_q + count : base_q - count;
        s_addr       = FORWARD ? base_s + count : base_s - count;
        at_edge      = (q_addr == EDGE) || (s_addr == EDGE);
        stop         = (next_run < next_best - DROP) || (next_count == LIMIT) || at_edge;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            active    <= 1'b0;
            run_score <= '0;
            best      <= '0;
            best_len  <= '0;
            count     <= '0;
            base_q    <= '0;
            base_s    <= '0;
        end else if (start) begin
            active    <= start_ok;
            run_score <= '0;
            best      <= '0;
            best_len  <= '0;
            count     <= '0;
            base_q    <= start_q;
            base_s    <= start_s;
        end else if (score_en && active) begin
            if (hit_boundary) begin
                active <= 1'b0;
            end else begin
                run_score <= next_run;
                count     <= next_count;
                if (next_run > best) begin
                    best     <= next_run;
                    best_len <= next_count;
                end
                if (stop) begin
                    active <= 1'b0;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/hit_ungap_extender.sv
// Ungapped X-drop extension of seed hits in both directions; UNGAP_THRESHOLD_EN drops HSPs scoring below SCORE_THRESH.
`default_nettype none

module hit_ungap_extender
    import blastn_pkg::*;
#(
    parameter int LENGTH_CHAR    = blastn_pkg::LENGTH_CHAR,
    parameter int LENGTH_COUNTER = blastn_pkg::LENGTH_COUNTER,
    parameter int MATCH          = blastn_pkg::MATCH_DEF,
    parameter int MISMATCH       = blastn_pkg::MISMATCH_DEF,
    parameter int X_DROP         = blastn_pkg::X_DROP_DEF,
    parameter int MAX_EXT        = 32,
    parameter int SCORE_THRESH   = 20
) (
    input  logic                        array_clk,
    input  logic                        reset,
    input  logic                        hit_empty,
    output logic                        read_HSP,
    input  logic [LENGTH_COUNTER-1:0]   hit_add_inQ,
    input  logic [LENGTH_COUNTER-1:0]   hit_add_inS,
    input  logic [LENGTH_COUNTER-1:0]   hit_length,
    output logic [LENGTH_COUNTER-1:0]   Q_address_F,
    output logic [LENGTH_COUNTER-1:0]   S_address_F,
    input  logic [LENGTH_CHAR-1:0]      Q_context_F,
    input  logic [LENGTH_CHAR-1:0]      S_context_F,
    output logic [LENGTH_COUNTER-1:0]   Q_address_R,
    output logic [LENGTH_COUNTER-1:0]   S_address_R,
    input  logic [LENGTH_CHAR-1:0]      Q_context_R,
    input  logic [LENGTH_CHAR-1:0]      S_context_R,
    output logic                        hsp_valid,
    input  logic                        hsp_ready,
    output logic [LENGTH_COUNTER-1:0]   hsp_add_inQ,
    output logic [LENGTH_COUNTER-1:0]   hsp_add_inS,
    output logic [LENGTH_COUNTER-1:0]   hsp_length,
    output logic [LENGTH_COUNTER-1:0]   hsp_score
);

`ifdef UNGAP_THRESHOLD_EN
    localparam bit THRESH_EN = 1'b1;
`else
    localparam bit THRESH_EN = 1'b0;
`endif

    ext_state_t                  state;
    ext_state_t                  state_next;

    logic [LENGTH_COUNTER-1:0]   seed_q;
    logic [LENGTH_COUNTER-1:0]   seed_s;
    logic [LENGTH_COUNTER-1:0]   seed_len;
    logic                        primed;

    logic [LENGTH_COUNTER:0]     fwd_q_wide;
    logic [LENGTH_COUNTER:0]     fwd_s_wide;
    logic                        fwd_ok;
    logic                        rev_ok;

    logic                        fwd_active;
    logic                        rev_active;
    logic signed [SCORE_W-1:0]   best_f;
    logic signed [SCORE_W-1:0]   best_r;
    logic [LENGTH_COUNTER-1:0]   len_f;
    logic [LENGTH_COUNTER-1:0]   len_r;

    logic                        load;
    logic                        score_en;
    logic                        finish;
    logic [SCORE_W-1:0]          seed_score;
    logic [SCORE_W-1:0]          score_sum;
    logic [SCORE_W-1:0]          len_sum;
    logic [LENGTH_COUNTER-1:0]   score_sat;
    logic                        keep;

    // A direction whose first address would already wrap never starts.
    always_comb begin
        fwd_q_wide = {1'b0, hit_add_inQ} + {1'b0, hit_length} + 1'b1;
        fwd_s_wide = {1'b0, hit_add_inS} + {1'b0, hit_length} + 1'b1;
        fwd_ok     = !fwd_q_wide[LENGTH_COUNTER] && !fwd_s_wide[LENGTH_COUNTER];
        rev_ok     = (hit_add_inQ != '0) && (hit_add_inS != '0);
        load       = (state == LOAD);
        score_en   = (state == EXTEND) && primed;
        finish     = (state == EXTEND) && !fwd_active && !rev_active;
        seed_score = SCORE_W'((int'(seed_len) + 1) * MATCH);
        score_sum  = seed_score + $unsigned(best_f) + $unsigned(best_r);
        len_sum    = SCORE_W'(seed_len) + SCORE_W'(len_f) + SCORE_W'(len_r);
        score_sat  = sat_count(score_sum);
        keep       = !THRESH_EN || (score_sat >= LENGTH_COUNTER'(SCORE_THRESH));
    end

    always_ff @(posedge array_clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        read_HSP   = 1'b0;
        hsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!hit_empty) begin
                    state_next = POP;
                end
            end
            POP: begin
                if (!hit_empty) begin
                    read_HSP   = 1'b1;
                    state_next = LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                state_next = EXTEND;
            end
            EXTEND: begin
                if (finish) begin
                    state_next = keep ? REPORT : IDLE;
                end
            end
            REPORT: begin
                hsp_valid = 1'b1;
                if (hsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Addresses are issued one cycle ahead of their context; 'primed' masks the fill cycle.
    always_ff @(posedge array_clk) begin
        if (!reset) begin
            seed_q      <= '0;
            seed_s      <= '0;
            seed_len    <= '0;
            primed      <= 1'b0;
            Q_address_F <= '0;
            S_address_F <= '0;
            Q_address_R <= '0;
            S_address_R <= '0;
            hsp_add_inQ <= '0;
            hsp_add_inS <= '0;
            hsp_length  <= '0;
            hsp_score   <= '0;
        end else begin
            if (load) begin
                seed_q   <= hit_add_inQ;
                seed_s   <= hit_add_inS;
                seed_len <= hit_length;
                primed   <= 1'b0;
                if (fwd_ok) begin
                    Q_address_F <= fwd_q_wide[LENGTH_COUNTER-1:0];
                    S_address_F <= fwd_s_wide[LENGTH_COUNTER-1:0];
                end
                if (rev_ok) begin
                    Q_address_R <= hit_add_inQ - 1'b1;
                    S_address_R <= hit_add_inS - 1'b1;
                end
            end
            if (state == EXTEND) begin
                primed <= 1'b1;
                if (fwd_active && (Q_address_F != '1) && (S_address_F != '1)) begin
                    Q_address_F <= Q_address_F + 1'b1;
                    S_address_F <= S_address_F + 1'b1;
                end
                if (rev_active && (Q_address_R != '0) && (S_address_R != '0)) begin
                    Q_address_R <= Q_address_R - 1'b1;
                    S_address_R <= S_address_R - 1'b1;
                end
            end
            if (finish) begin
                hsp_add_inQ <= seed_q - len_r;
                hsp_add_inS <= seed_s - len_r;
                hsp_length  <= sat_count(len_sum);
                hsp_score   <= score_sat;
            end
        end
    end

    ungap_dir_scorer #(
        .LENGTH_CHAR    (LENGTH_CHAR),
        .LENGTH_COUNTER (LENGTH_COUNTER),
        .MATCH          (MATCH),
        .MISMATCH       (MISMATCH),
        .X_DROP         (X_DROP),
        .MAX_EXT        (MAX_EXT),
        .FORWARD        (1'b1)
    ) u_fwd (
        .clk      (array_clk),
        .reset    (reset),
        .start    (load),
        .start_ok (fwd_ok),
        .start_q  (fwd_q_wide[LENGTH_COUNTER-1:0]),
        .start_s  (fwd_s_wide[LENGTH_COUNTER-1:0]),
        .score_en (score_en),
        .q_char   (Q_context_F),
        .s_char   (S_context_F),
        .active   (fwd_active),
        .best     (best_f),
        .best_len (len_f)
    );

    ungap_dir_scorer #(
        .LENGTH_CHAR    (LENGTH_CHAR),
        .LENGTH_COUNTER (LENGTH_COUNTER),
        .MATCH          (MATCH),
        .MISMATCH       (MISMATCH),
        .X_DROP         (X_DROP),
        .MAX_EXT        (MAX_EXT),
        .FORWARD        (1'b0)
    ) u_rev (
        .clk      (array_clk),
        .reset    (reset),
        .start    (load),
        .start_ok (rev_ok),
        .start_q  (hit_add_inQ - 1'b1),
        .start_s  (hit_add_inS - 1'b1),
        .score_en (score_en),
        .q_char   (Q_context_R),
        .s_char   (S_context_R),
        .active   (rev_active),
        .best     (best_r),
        .best_len (len_r)
    );

endmodule

`default_nettype wire

// File: tb/tb_hit_ungap_extender.sv
// Randomized and directed self-checking bench for hit_ungap_extender against a software extension model.
`default_nettype none
`timescale 1ns/1ps

module tb_hit_ungap_extender;

    localparam int MATCH        = 1;
    localparam int MISMATCH     = 3;
    localparam int X_DROP       = 10;
    localparam int MAX_EXT      = 32;
    localparam int SCORE_THRESH = 20;
`ifdef UNGAP_THRESHOLD_EN
    localparam bit THR = 1'b1;
`else
    localparam bit THR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hit_empty;
    logic       read_HSP;
    logic [7:0] hit_add_inQ = '0, hit_add_inS = '0, hit_length = '0;
    logic [7:0] Q_address_F, S_address_F, Q_address_R, S_address_R;
    logic [2:0] Q_context_F = '0, S_context_F = '0, Q_context_R = '0, S_context_R = '0;
    logic       hsp_valid;
    logic       hsp_ready = 1'b0;
    logic [7:0] hsp_add_inQ, hsp_add_inS, hsp_length, hsp_score;

    int errors = 0;
    int checks = 0;

    logic [2:0] q_mem [256];
    logic [2:0] s_mem [256];
    logic [7:0] fq [64];
    logic [7:0] fs [64];
    logic [7:0] fl [64];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int pop_viol = 0;

    always #5 clk = ~clk;

    hit_ungap_extender dut (
        .array_clk   (clk),
        .reset       (reset),
        .hit_empty   (hit_empty),
        .read_HSP    (read_HSP),
        .hit_add_inQ (hit_add_inQ),
        .hit_add_inS (hit_add_inS),
        .hit_length  (hit_length),
        .Q_address_F (Q_address_F),
        .S_address_F (S_address_F),
        .Q_context_F (Q_context_F),
        .S_context_F (S_context_F),
        .Q_address_R (Q_address_R),
        .S_address_R (S_address_R),
        .Q_context_R (Q_context_R),
        .S_context_R (S_context_R),
        .hsp_valid   (hsp_valid),
        .hsp_ready   (hsp_ready),
        .hsp_add_inQ (hsp_add_inQ),
        .hsp_add_inS (hsp_add_inS),
        .hsp_length  (hsp_length),
        .hsp_score   (hsp_score)
    );

    assign hit_empty = (wr_ptr == rd_ptr);

    // Hit FIFO and context memories, both with one cycle of read latency.
    always @(posedge clk) begin
        if (read_HSP) begin
            if (hit_empty) begin
                pop_viol <= pop_viol + 1;
            end else begin
                hit_add_inQ <= fq[rd_ptr % 64];
                hit_add_inS <= fs[rd_ptr % 64];
                hit_length  <= fl[rd_ptr % 64];
                rd_ptr      <= rd_ptr + 1;
            end
        end
        Q_context_F <= q_mem[Q_address_F];
        S_context_F <= s_mem[S_address_F];
        Q_context_R <= q_mem[Q_address_R];
        S_context_R <= s_mem[S_address_R];
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_hit(input int q, input int s, input int len);
        fq[wr_ptr % 64] = 8'(q);
        fs[wr_ptr % 64] = 8'(s);
        fl[wr_ptr % 64] = 8'(len);
        wr_ptr++;
    endtask

    // Walk one direction from (q0,s0) with step +1/-1 following the X-drop rules.
    task automatic extend_dir(input int q0, input int s0, input int step,
                              output int best, output int blen);
        int run, aq, as_;
        run = 0; best = 0; blen = 0;
        for (int n = 0; n < MAX_EXT; n++) begin
            aq  = q0 + step * n;
            as_ = s0 + step * n;
            if (aq < 0 || aq > 255 || as_ < 0 || as_ > 255) break;
            if (q_mem[aq] == 3'b000 || s_mem[as_] == 3'b000) break;
            run += (q_mem[aq] == s_mem[as_]) ? MATCH : -MISMATCH;
            if (run > best) begin
                best = run;
                blen = n + 1;
            end
            if (run < best - X_DROP) break;
        end
    endtask

    task automatic model(input int q, input int s, input int len, output bit drop,
                         output int eq, output int es, output int el, output int esc);
        int bf, lf, br, lr;
        extend_dir(q + len + 1, s + len + 1, 1, bf, lf);
        extend_dir(q - 1, s - 1, -1, br, lr);
        esc  = (len + 1) * MATCH + bf + br;
        if (esc > 255) esc = 255;
        el   = len + lf + lr;
        if (el > 255) el = 255;
        eq   = (q - lr) & 255;
        es   = (s - lr) & 255;
        drop = THR && (esc < SCORE_THRESH);
    endtask

    task automatic expect_hsp(input string tag, input int eq, input int es, input int el,
                              input int esc, input int stall);
        int t;
        int pops;
        bit stable;
        logic [31:0] snap;
        t = 0;
        while (!hsp_valid && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!hsp_valid) begin
            chk({tag, "_timeout"}, 0, 1);
            return;
        end
        chk({tag, "_q"}, hsp_add_inQ, eq);
        chk({tag, "_s"}, hsp_add_inS, es);
        chk({tag, "_len"}, hsp_length, el);
        chk({tag, "_score"}, hsp_score, esc);
        if (stall > 0) begin
            snap   = {hsp_add_inQ, hsp_add_inS, hsp_length, hsp_score};
            pops   = rd_ptr;
            stable = 1'b1;
            repeat (stall) begin
                @(negedge clk);
                if (!hsp_valid || snap != {hsp_add_inQ, hsp_add_inS, hsp_length, hsp_score})
                    stable = 1'b0;
            end
            chk({tag, "_stable"}, int'(stable), 1);
            chk({tag, "_nopop"}, rd_ptr, pops);
        end
        hsp_ready = 1'b1;
        @(negedge clk);
        hsp_ready = 1'b0;
        chk({tag, "_done"}, int'(hsp_valid), 0);
    endtask

    task automatic expect_none(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (hsp_valid) seen = 1'b1;
        end
        chk({tag, "_none"}, int'(seen), 0);
    endtask

    task automatic rand_mem(input int off);
        int k;
        for (int j = 0; j < 256; j++) begin
            q_mem[j] = 3'($urandom_range(1, 4));
            if ($urandom_range(0, 99) < 3) q_mem[j] = 3'b000;
        end
        for (int j = 0; j < 256; j++) begin
            k = j + off;
            if (k >= 0 && k <= 255 && $urandom_range(0, 99) < 85) s_mem[j] = q_mem[k];
            else s_mem[j] = 3'($urandom_range(1, 4));
        end
    endtask

    task automatic run_model_hit(input string tag, input int q, input int s, input int len);
        bit drop;
        int eq, es, el, esc;
        model(q, s, len, drop, eq, es, el, esc);
        if (drop) expect_none(tag, 100);
        else expect_hsp(tag, eq, es, el, esc, 0);
    endtask

    initial begin
        int q, s, len, q2, s2, len2, t;
        for (int j = 0; j < 256; j++) begin
            q_mem[j] = 3'b001;
            s_mem[j] = 3'b001;
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ctrl", int'({read_HSP, hsp_valid}), 0);
        chk("rst_addr", int'({Q_address_F, S_address_F, Q_address_R, S_address_R}), 0);
        chk("rst_hsp", int'({hsp_add_inQ, hsp_add_inS, hsp_length, hsp_score}), 0);
        reset = 1'b1;

        // Empty FIFO: no pops
        repeat (100) @(negedge clk);
        chk("empty_pops", rd_ptr, 0);

        // Identical sequences bounded by 000 at +18/-6, with a stalled handshake
        for (int j = 0; j < 256; j++) begin
            q_mem[j] = 3'((j % 4) + 1);
            s_mem[j] = 3'(((j + 30) % 4) + 1);
        end
        q_mem[58] = 3'b000; s_mem[28] = 3'b000;
        q_mem[34] = 3'b000; s_mem[4]  = 3'b000;
        push_hit(40, 10, 7);
        push_hit(40, 10, 7);
        expect_hsp("ident_stall", 35, 5, 22, 23, 20);
        chk("ident_pops1", rd_ptr, 1);
        expect_hsp("ident_2", 35, 5, 22, 23, 0);
        chk("ident_pops2", rd_ptr, 2);

        // All-mismatch context
        for (int j = 0; j < 256; j++) begin
            q_mem[j] = 3'b001;
            s_mem[j] = 3'b010;
        end
        push_hit(50, 50, 3);
        if (THR) expect_none("mism", 100);
        else expect_hsp("mism", 50, 50, 3, 4, 0);
        chk("mism_pops", rd_ptr, 3);

        // Seed at address 0: reverse never starts, forward runs MAX_EXT
        for (int j = 0; j < 256; j++) begin
            q_mem[j] = 3'b011;
            s_mem[j] = 3'b011;
        end
        push_hit(0, 0, 0);
        expect_hsp("zero", 0, 0, 32, 33, 0);

        // Reset during EXTEND cycle 5
        push_hit(100, 100, 3);
        t = 0;
        while (!read_HSP && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("mid_pop_seen", int'(read_HSP), 1);
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid_ctrl", int'({read_HSP, hsp_valid}), 0);
        chk("mid_addr", int'({Q_address_F, S_address_F, Q_address_R, S_address_R}), 0);
        chk("mid_hsp", int'({hsp_add_inQ, hsp_add_inS, hsp_length, hsp_score}), 0);
        expect_none("mid_discard", 60);
        push_hit(100, 100, 3);
        expect_hsp("mid_after", 68, 68, 67, 68, 0);

        // Randomized hits, pairs queued back to back
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(0, 15);
            q   = $urandom_range(0, 255 - len);
            s   = $urandom_range(0, 255 - len);
            rand_mem(q - s);
            len2 = $urandom_range(0, 15);
            q2   = $urandom_range(0, 255 - len2);
            s2   = (q2 - (q - s) >= 0 && q2 - (q - s) <= 255 - len2) ? q2 - (q - s) : $urandom_range(0, 255 - len2);
            push_hit(q, s, len);
            push_hit(q2, s2, len2);
            run_model_hit($sformatf("rnd%0da", it), q, s, len);
            run_model_hit($sformatf("rnd%0db", it), q2, s2, len2);
            chk($sformatf("rnd%0d_pops", it), rd_ptr, wr_ptr);
        end

        chk("pop_when_empty", pop_viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
